// File: rtl/dec139_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that drives one half of a
// dual 2-to-4 active-low decoder.
package dec139_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURNAROUND
    } state_t;

    localparam int HOLD_MAX_DEF  = 8;
    localparam int TA_CYCLES_DEF = 1;

    // Active-low one-hot grant, identical to the decoder's Y3..Y0 with G low.
    function automatic logic [3:0] grant_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/dec139_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first asserted request scanning
// ptr+1, ptr+2, ptr+3, ptr (mod 4), so the last-served index ranks last.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/dec139_rr_arbiter.sv
// Round-robin arbiter sharing one 2-to-4 decoder half among four requesters;
// every output is a flop, so REQ never reaches G/B/A combinationally.
module dec139_rr_arbiter
    import dec139_pkg::*;
#(
    parameter int HOLD_MAX  = HOLD_MAX_DEF,
    parameter int TA_CYCLES = TA_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    output logic       G,
    output logic       B,
    output logic       A,
    output logic [3:0] GNT_N,
    output logic       BUSY,
    output logic [1:0] LAST
);

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
    localparam logic [3:0] TA_C       = 4'(TA_CYCLES);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [1:0] last_q;
    logic [7:0] cnt;
    logic [3:0] tcnt;
    logic [3:0] gnt_n_q;
    logic       g_q;
    logic       busy_q;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       launch;

    rr_pick4 u_pick (
        .req   (REQ),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A new grant starts from IDLE, or on the edge that takes TCNT to zero.
    assign launch = pick_valid &&
                    ((state == IDLE) || ((state == TURNAROUND) && (tcnt <= 4'd1)));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            g_q     <= 1'b1;
            sel     <= 2'b00;
            gnt_n_q <= 4'b1111;
            busy_q  <= 1'b0;
            last_q  <= 2'b11;
            ptr     <= 2'b11;
            cnt     <= 8'd0;
            tcnt    <= 4'd0;
        end else if (launch) begin
            state   <= GRANT;
            g_q     <= 1'b0;
            sel     <= pick_idx;
            gnt_n_q <= grant_n(pick_idx);
            busy_q  <= 1'b1;
            cnt     <= 8'd1;
            tcnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: ;
                GRANT: begin
                    if (REQ[sel] && (cnt < HOLD_MAX_C)) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        // Select lines stay put so the decoder sees no glitch.
                        state   <= TURNAROUND;
                        g_q     <= 1'b1;
                        gnt_n_q <= 4'b1111;
                        ptr     <= sel;
                        last_q  <= sel;
                        tcnt    <= TA_C;
                    end
                end
                TURNAROUND: begin
                    if (tcnt > 4'd1) begin
                        tcnt <= tcnt - 4'd1;
                    end else begin
                        tcnt   <= 4'd0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    g_q     <= 1'b1;
                    gnt_n_q <= 4'b1111;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign G     = g_q;
    assign B     = sel[1];
    assign A     = sel[0];
    assign GNT_N = gnt_n_q;
    assign BUSY  = busy_q;
    assign LAST  = last_q;

endmodule

// File: tb/tb_dec139_rr_arbiter.sv
// Directed bench for dec139_rr_arbiter: a vector table plus hand-written
// sequences for rotation and mid-grant reset, with a 2-to-4 decoder model.
module tb_dec139_rr_arbiter;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic       G;
    logic       B;
    logic       A;
    logic [3:0] GNT_N;
    logic       BUSY;
    logic [1:0] LAST;

    int n_checks = 0;
    int n_fail   = 0;

    dec139_rr_arbiter #(
        .HOLD_MAX  (8),
        .TA_CYCLES (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .REQ   (REQ),
        .G     (G),
        .B     (B),
        .A     (A),
        .GNT_N (GNT_N),
        .BUSY  (BUSY),
        .LAST  (LAST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       g;
        logic [1:0] ba;
        logic [3:0] gnt_n;
        logic       busy;
        logic [1:0] last;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    logic [3:0] onehot_n [4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic [3:0] req);
        RST_N = rst_n;
        REQ   = req;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic g, input logic [1:0] ba,
                             input logic [3:0] gnt_n, input logic busy, input logic [1:0] last);
        check({tag, ".G"},     8'(G),      8'(g));
        check({tag, ".BA"},    8'({B, A}), 8'(ba));
        check({tag, ".GNT_N"}, 8'(GNT_N),  8'(gnt_n));
        check({tag, ".BUSY"},  8'(BUSY),   8'(busy));
        check({tag, ".LAST"},  8'(LAST),   8'(last));
    endtask

    // Decoder model and select-stability watch, sampled on the falling edge.
    logic       mon_on = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_g;
    logic [1:0] prev_ba;
    logic [3:0] dec_y;

    always @(negedge CLK) begin
        if (mon_on) begin
            dec_y = 4'b1111;
            if (G == 1'b0) begin
                case ({B, A})
                    2'd0: dec_y[0] = 1'b0;
                    2'd1: dec_y[1] = 1'b0;
                    2'd2: dec_y[2] = 1'b0;
                    default: dec_y[3] = 1'b0;
                endcase
            end
            check("decoder_y", 8'(GNT_N), 8'(dec_y));
            if (prev_valid && !prev_g && !G)
                check("sel_stable", 8'({B, A}), 8'(prev_ba));
            prev_g     = G;
            prev_ba    = {B, A};
            prev_valid = 1'b1;
        end
    end

    initial begin
        onehot_n[0] = 4'b1110;
        onehot_n[1] = 4'b1101;
        onehot_n[2] = 4'b1011;
        onehot_n[3] = 4'b0111;

        //          rst   req      g    ba     gnt_n    busy  last
        vecs[0]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b1111, 1'b0, 2'd3}; // reset
        vecs[1]  = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b1111, 1'b0, 2'd3};
        vecs[2]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b1110, 1'b1, 2'd3}; // first grant idx0
        vecs[3]  = '{1'b1, 4'b0000, 1'b1, 2'd0, 4'b1111, 1'b1, 2'd0}; // release
        vecs[4]  = '{1'b1, 4'b0000, 1'b1, 2'd0, 4'b1111, 1'b0, 2'd0}; // back to idle
        vecs[5]  = '{1'b1, 4'b0100, 1'b0, 2'd2, 4'b1011, 1'b1, 2'd0}; // early release
        vecs[6]  = '{1'b1, 4'b0100, 1'b0, 2'd2, 4'b1011, 1'b1, 2'd0};
        vecs[7]  = '{1'b1, 4'b0100, 1'b0, 2'd2, 4'b1011, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 4'b0000, 1'b1, 2'd2, 4'b1111, 1'b1, 2'd2};
        vecs[9]  = '{1'b1, 4'b0000, 1'b1, 2'd2, 4'b1111, 1'b0, 2'd2};
        vecs[10] = '{1'b1, 4'b0010, 1'b0, 2'd1, 4'b1101, 1'b1, 2'd2}; // serve idx1
        vecs[11] = '{1'b1, 4'b0000, 1'b1, 2'd1, 4'b1111, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 4'b0011, 1'b0, 2'd0, 4'b1110, 1'b1, 2'd1}; // skip 2,3 -> idx0
        vecs[13] = '{1'b1, 4'b0010, 1'b1, 2'd0, 4'b1111, 1'b1, 2'd0};
        vecs[14] = '{1'b1, 4'b0011, 1'b0, 2'd1, 4'b1101, 1'b1, 2'd0}; // then idx1
        vecs[15] = '{1'b1, 4'b0000, 1'b1, 2'd1, 4'b1111, 1'b1, 2'd1};
        vecs[16] = '{1'b1, 4'b0000, 1'b1, 2'd1, 4'b1111, 1'b0, 2'd1};
        vecs[17] = '{1'b1, 4'b0100, 1'b0, 2'd2, 4'b1011, 1'b1, 2'd1};
        vecs[18] = '{1'b1, 4'b0000, 1'b1, 2'd2, 4'b1111, 1'b1, 2'd2};
        vecs[19] = '{1'b1, 4'b0101, 1'b0, 2'd0, 4'b1110, 1'b1, 2'd2}; // re-raised idx2 ranks last

        RST_N = 1'b0;
        REQ   = 4'b0000;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst_n, vecs[i].req);
            mon_on = 1'b1;
            check_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].ba,
                      vecs[i].gnt_n, vecs[i].busy, vecs[i].last);
        end

        // Full rotation from reset under a continuous request on all lines.
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0000);
        check_all("rot_reset", 1'b1, 2'd0, 4'b1111, 1'b0, 2'd3);
        for (int gi = 0; gi < 5; gi++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 4'b1111);
                check_all($sformatf("rot%0d_hold%0d", gi, c), 1'b0, 2'(gi % 4),
                          onehot_n[gi % 4], 1'b1, (gi == 0) ? 2'd3 : 2'((gi + 3) % 4));
            end
            step(1'b1, 4'b1111);
            check_all($sformatf("rot%0d_gap", gi), 1'b1, 2'(gi % 4), 4'b1111, 1'b1, 2'(gi % 4));
        end

        // Reset in the middle of a grant at CNT=4.
        step(1'b1, 4'b1111);
        check_all("mid_grant1", 1'b0, 2'd1, 4'b1101, 1'b1, 2'd0);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        check_all("mid_grant4", 1'b0, 2'd1, 4'b1101, 1'b1, 2'd0);
        step(1'b0, 4'b1111);
        check_all("mid_reset", 1'b1, 2'd0, 4'b1111, 1'b0, 2'd3);
        step(1'b1, 4'b1111);
        check_all("post_reset_grant", 1'b0, 2'd0, 4'b1110, 1'b1, 2'd3);

        step(1'b1, 4'b0000);
        check_all("final_release", 1'b1, 2'd0, 4'b1111, 1'b1, 2'd0);
        @(negedge CLK);
        mon_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dec139_rr_arbiter.md
# dec139_rr_arbiter

- Round-robin arbiter that shares one half of a dual 2-to-4 active-low decoder among four requesters.
- Samples four active-high requests and grants one requester at a time.
- Drives the decoder's enable (G, active-low) and select (B, A) lines.
- Also outputs the resulting active-low grant vector, so the board-level chip-select fan-out stays in the decoder and the bench can self-check.

## Interface

Parameters:
- HOLD_MAX, default 8: maximum consecutive cycles one requester may hold G low (legal range 1..255).
- TA_CYCLES, default 1: dead cycles with G high between two grants (legal range 1..15).

Ports:
- CLK  input  1  Single system clock; all state changes on the rising edge.
- RST_N  input  1  Reset, active-low, synchronous (sampled on the CLK rising edge).
- REQ  input  4  Request lines, active-high; REQ[i] belongs to requester i.
- G  output  1  Decoder enable, active-low.
- B  output  1  Decoder select MSB.
- A  output  1  Decoder select LSB.
- GNT_N  output  4  Active-low one-hot grant; equals the decoder's Y3..Y0 for the current {G,B,A}.
- BUSY  output  1  High while in GRANT or TURNAROUND.
- LAST  output  2  Index of the most recently completed grant.

## Operation

State machine:
- Three states: IDLE, GRANT, TURNAROUND.
- Rotating pointer PTR (2 bits) holds the last-served index.
- Hold counter CNT is 8 bits; turnaround counter TCNT is 4 bits.

Reset:
- Applies when RST_N=0 at a rising edge.
- State → IDLE, G=1, {B,A}=2'b00, GNT_N=4'b1111, BUSY=0, LAST=2'b11.
- PTR=3, so requester 0 has first priority; CNT=0, TCNT=0.
- Reset asserted mid-grant forces G=1 at that same edge. There is no turnaround after reset.

IDLE:
- If REQ=0, stay in IDLE.
- Otherwise pick the first asserted REQ scanning PTR+1, PTR+2, PTR+3, PTR (mod 4).
- Load {B,A}=idx, set G=0, CNT=1, go to GRANT.

GRANT:
- {B,A} is frozen.
- If REQ[idx]=1 and CNT<HOLD_MAX: CNT+=1, stay in GRANT.
- If REQ[idx]=0 or CNT==HOLD_MAX: set G=1, PTR=idx, LAST=idx, TCNT=TA_CYCLES, go to TURNAROUND.
- Requests from other requesters never preempt the current grant.

TURNAROUND:
- G=1 and {B,A} hold their last value, so there is no select glitch.
- TCNT decrements each cycle. When TCNT reaches 0 the block re-arbitrates exactly as in IDLE, in the same cycle.
- The requester just served is scanned last.

Outputs:
- GNT_N = 4'b1111 when G=1; otherwise ~(4'b0001<<{B,A}).
- All outputs are registered; no combinational path from REQ to any output.

## Timing

- Grant latency: REQ seen at edge t in IDLE → G=0 and the GNT_N bit low after edge t (1 cycle).
- Release: REQ[idx]=0 sampled at edge t → G=1 after edge t.
- Maximum hold: G stays low for exactly HOLD_MAX cycles under a continuous request.
- Gap between grants: exactly TA_CYCLES cycles of G=1. The next grant appears at the edge that takes TCNT to 0.
- Simultaneous requests: resolved by rotation only; no fixed priority except right after reset (order 0,1,2,3).
- A requester that drops and re-raises REQ during its own turnaround competes normally but ranks last.
- {B,A} change only on the edge where G goes from 1 to 0. They never change while G=0.

## Structure

Shared package dec139_pkg holds:
- State enum (IDLE, GRANT, TURNAROUND).
- Default constants HOLD_MAX_DEF=8 and TA_CYCLES_DEF=1.
- A function that maps a 2-bit index to the active-low 4-bit grant.

Sub-module rr_pick4:
- Purely combational.
- Inputs: REQ[3:0], PTR[1:0]. Outputs: valid, idx[1:0].
- Instantiated once by the FSM.

## Test plan

- **Reset:** RST_N=0 for 2 cycles with REQ=4'b1111 → G=1, GNT_N=4'b1111, LAST=3. After release, the first grant goes to idx 0 (B=0, A=0, GNT_N=4'b1110).
- **Rotation:** REQ=4'b1111 held, HOLD_MAX=8, TA_CYCLES=1 → grant order 0,1,2,3,0. Each grant is 8 cycles of G=0, with 1 gap cycle between grants.
- **Early release:** only REQ[2]=1 for 3 cycles, then 0 → G low for 3 cycles with GNT_N=4'b1011. G=1 the cycle after the drop; LAST=2.
- **Rotation skip:** after serving idx 1, assert REQ=4'b0011 → next grant is idx 0 (skips 2 and 3); the grant after that is idx 1.
- **Mid-grant reset:** RST_N=0 during GRANT at CNT=4 → G=1 at that edge, state IDLE, PTR=3. The next grant honours the reset priority.
- **Decoder cross-check:** instantiate the dual 2-to-4 decoder model on G, B, A → its Y outputs equal GNT_N every cycle, and {B,A} never change while G=0.
